// File: rtl/axicb_fifo_pkg.sv
// Purpose: shared sizing helpers and parameter legality checks for the crossbar FIFOs.
// Latency: n/a (elaboration-time constants only).
// Backpressure: n/a.
package axicb_fifo_pkg;

    // Total words the FWFT FIFO can hold: storage array plus the output register.
    function automatic int fifo_cap(input int aw);
        return (2 ** aw) + 1;
    endfunction

    // almost_full threshold must be reachable and non-trivial.
    function automatic bit af_thresh_ok(input int aw, input int thresh);
        return (thresh >= 1) && (thresh <= fifo_cap(aw));
    endfunction

    // almost_empty threshold must leave the full state distinguishable.
    function automatic bit ae_thresh_ok(input int aw, input int thresh);
        return (thresh >= 0) && (thresh <= fifo_cap(aw) - 1);
    endfunction

endpackage

// File: rtl/axicb_scfifo_fwft_if.sv
// Purpose: bundles the FIFO data path, handshake and status signals.
// Latency: n/a (wires only).
// Backpressure: producer watches full/almost_full, consumer watches empty.
interface axicb_scfifo_fwft_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  flush;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  push;
    logic                  full;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  pull;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;

    // FIFO side.
    modport slave (
        input  flush, data_in, push, pull,
        output full, data_out, empty, count, almost_full, almost_empty, overflow, underflow
    );

    // User side.
    modport master (
        output flush, data_in, push, pull,
        input  full, data_out, empty, count, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/axicb_fifo_regfile.sv
// Purpose: storage array, synchronous write, asynchronous read, no reset.
// Latency: write visible on the read port the cycle after wr_en.
// Backpressure: none; the caller guarantees it never overwrites live words.
module axicb_fifo_regfile #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Store the incoming word at the write address.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[addr_in] <= data_in;
        end
    end

    assign data_out = mem[addr_out];
endmodule

// File: rtl/axicb_scfifo_fwft.sv
// Purpose: single-clock first-word-fall-through FIFO with registered head word and status.
// Latency: push to visible data_out is 1 cycle; all status outputs come from registers.
// Backpressure: push refused while full (sets overflow), pull refused while empty (sets underflow).
module axicb_scfifo_fwft
    import axicb_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int AF_THRESH  = 2 ** ADDR_WIDTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 srst,
    axicb_scfifo_fwft_if.slave   fifo
);
    localparam int                CAP     = fifo_cap(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] CAP_V   = CAP[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_V    = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_V    = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    if (!af_thresh_ok(ADDR_WIDTH, AF_THRESH)) begin : g_bad_af
        $error("axicb_scfifo_fwft: AF_THRESH out of range 1..CAP");
    end
    if (!ae_thresh_ok(ADDR_WIDTH, AE_THRESH)) begin : g_bad_ae
        $error("axicb_scfifo_fwft: AE_THRESH out of range 0..CAP-1");
    end

    logic [ADDR_WIDTH:0]   wrptr;
    logic [ADDR_WIDTH:0]   rdptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   arr_cnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full_w;
    logic                  empty_w;
    logic                  push_ok;
    logic                  pull_ok;
    logic                  out_free;
    logic                  refill;
    logic                  direct;
    logic                  wr_en;

    // Accept decisions use registered full/empty only, so a same-cycle pull never frees room for a push.
    assign full_w   = (count_q == CAP_V);
    assign empty_w  = ~out_valid;
    assign push_ok  = fifo.push & ~full_w;
    assign pull_ok  = fifo.pull & ~empty_w;
    assign arr_cnt  = wrptr - rdptr;
    assign out_free = ~out_valid | pull_ok;
    assign refill   = (arr_cnt != '0) & out_free;
    assign direct   = push_ok & (arr_cnt == '0) & out_free;
    assign wr_en    = push_ok & ~direct & ~fifo.flush & ~srst;

    axicb_fifo_regfile #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regfile (
        .aclk     (aclk),
        .wr_en    (wr_en),
        .addr_in  (wrptr[ADDR_WIDTH-1:0]),
        .data_in  (fifo.data_in),
        .addr_out (rdptr[ADDR_WIDTH-1:0]),
        .data_out (rd_dat)
    );

    // Pointer, occupancy, output-valid and sticky error flag bookkeeping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wrptr       <= '0;
            rdptr       <= '0;
            count_q     <= '0;
            out_valid   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (srst) begin
            wrptr       <= '0;
            rdptr       <= '0;
            count_q     <= '0;
            out_valid   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (fifo.flush) begin
            wrptr     <= '0;
            rdptr     <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (wr_en) begin
                wrptr <= wrptr + PTR_ONE;
            end
            if (refill) begin
                rdptr <= rdptr + PTR_ONE;
            end
            if (refill | direct) begin
                out_valid <= 1'b1;
            end else if (pull_ok) begin
                out_valid <= 1'b0;
            end
            count_q <= count_q + {{ADDR_WIDTH{1'b0}}, push_ok} - {{ADDR_WIDTH{1'b0}}, pull_ok};
            if (fifo.push & full_w) begin
                overflow_q <= 1'b1;
            end
            if (fifo.pull & empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Head-word register: refill from the array wins over the direct bypass; flush leaves it untouched.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dout_q <= '0;
        end else if (srst) begin
            dout_q <= '0;
        end else if (!fifo.flush) begin
            if (refill) begin
                dout_q <= rd_dat;
            end else if (direct) begin
                dout_q <= fifo.data_in;
            end
        end
    end

    assign fifo.full         = full_w;
    assign fifo.empty        = empty_w;
    assign fifo.data_out     = dout_q;
    assign fifo.count        = count_q;
    assign fifo.almost_full  = (count_q >= AF_V);
    assign fifo.almost_empty = (count_q <= AE_V);
    assign fifo.overflow     = overflow_q;
    assign fifo.underflow    = underflow_q;
endmodule

// File: tb/tb_axicb_scfifo_fwft.sv
// Purpose: directed self-checking bench for the FWFT FIFO (ADDR_WIDTH=2, CAP=5).
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises full/overflow and empty/underflow paths.
module tb_axicb_scfifo_fwft;
    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic srst    = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    axicb_scfifo_fwft_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) ifc ();

    axicb_scfifo_fwft #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .AF_THRESH  (4),
        .AE_THRESH  (1)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .fifo    (ifc)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ifc.flush   = 1'b0;
        ifc.push    = 1'b0;
        ifc.pull    = 1'b0;
        ifc.data_in = 8'h00;

        // Reset state
        #3;
        chk("rst_empty", 32'(ifc.empty), 32'd1);
        chk("rst_full", 32'(ifc.full), 32'd0);
        chk("rst_count", 32'(ifc.count), 32'd0);
        chk("rst_dout", 32'(ifc.data_out), 32'h00);
        chk("rst_ae", 32'(ifc.almost_empty), 32'd1);
        chk("rst_af", 32'(ifc.almost_full), 32'd0);
        chk("rst_ovf", 32'(ifc.overflow), 32'd0);
        chk("rst_unf", 32'(ifc.underflow), 32'd0);
        #10;
        aresetn = 1'b1;
        tick();

        // Single word
        ifc.push = 1'b1; ifc.data_in = 8'hA5;
        tick();
        ifc.push = 1'b0;
        chk("sw_empty", 32'(ifc.empty), 32'd0);
        chk("sw_dout", 32'(ifc.data_out), 32'hA5);
        chk("sw_count", 32'(ifc.count), 32'd1);
        chk("sw_ae", 32'(ifc.almost_empty), 32'd1);
        ifc.pull = 1'b1;
        tick();
        ifc.pull = 1'b0;
        chk("sw_empty2", 32'(ifc.empty), 32'd1);
        chk("sw_count2", 32'(ifc.count), 32'd0);

        // Fill to capacity, then one refused push
        for (int i = 1; i <= 5; i++) begin
            ifc.push = 1'b1; ifc.data_in = 8'(i);
            tick();
            chk("fill_count", 32'(ifc.count), 32'(i));
            chk("fill_af", 32'(ifc.almost_full), 32'(i >= 4));
            chk("fill_full", 32'(ifc.full), 32'(i == 5));
            chk("fill_ae", 32'(ifc.almost_empty), 32'(i <= 1));
        end
        ifc.data_in = 8'h06;
        tick();
        ifc.push = 1'b0;
        chk("fill_ovf", 32'(ifc.overflow), 32'd1);
        chk("fill_count6", 32'(ifc.count), 32'd5);

        // Drain in order
        for (int i = 1; i <= 5; i++) begin
            chk("drain_dout", 32'(ifc.data_out), 32'(i));
            chk("drain_empty", 32'(ifc.empty), 32'd0);
            ifc.pull = 1'b1;
            tick();
        end
        ifc.pull = 1'b0;
        chk("drain_empty_end", 32'(ifc.empty), 32'd1);
        chk("drain_count_end", 32'(ifc.count), 32'd0);

        // srst clears the sticky overflow
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_ovf", 32'(ifc.overflow), 32'd0);

        // Streaming at count=1, data 0x10..0x23
        ifc.push = 1'b1; ifc.data_in = 8'h10;
        tick();
        for (int k = 0; k < 19; k++) begin
            chk("str_dout", 32'(ifc.data_out), 32'(8'h10 + k));
            ifc.push = 1'b1; ifc.pull = 1'b1; ifc.data_in = 8'(8'h11 + k);
            tick();
            chk("str_count", 32'(ifc.count), 32'd1);
        end
        ifc.push = 1'b0;
        chk("str_last", 32'(ifc.data_out), 32'h23);
        tick();
        ifc.pull = 1'b0;
        chk("str_empty", 32'(ifc.empty), 32'd1);
        chk("str_ovf", 32'(ifc.overflow), 32'd0);
        chk("str_unf", 32'(ifc.underflow), 32'd0);

        // Full with simultaneous push+pull: push refused
        for (int i = 1; i <= 5; i++) begin
            ifc.push = 1'b1; ifc.data_in = 8'(8'h30 + i);
            tick();
        end
        chk("fpp_full", 32'(ifc.full), 32'd1);
        ifc.push = 1'b1; ifc.pull = 1'b1; ifc.data_in = 8'h36;
        tick();
        ifc.push = 1'b0; ifc.pull = 1'b0;
        chk("fpp_ovf", 32'(ifc.overflow), 32'd1);
        chk("fpp_count", 32'(ifc.count), 32'd4);
        chk("fpp_dout", 32'(ifc.data_out), 32'h32);

        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("srst_count", 32'(ifc.count), 32'd0);
        chk("srst_dout", 32'(ifc.data_out), 32'h00);
        chk("srst_ovf2", 32'(ifc.overflow), 32'd0);

        // Underflow, then flush keeps it
        ifc.pull = 1'b1;
        tick();
        ifc.pull = 1'b0;
        chk("unf_flag", 32'(ifc.underflow), 32'd1);
        chk("unf_count", 32'(ifc.count), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            ifc.push = 1'b1; ifc.data_in = 8'(8'h40 + i);
            tick();
        end
        ifc.push = 1'b0;
        chk("pre_flush_count", 32'(ifc.count), 32'd3);
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        chk("flush_empty", 32'(ifc.empty), 32'd1);
        chk("flush_count", 32'(ifc.count), 32'd0);
        chk("flush_unf", 32'(ifc.underflow), 32'd1);
        chk("flush_dout", 32'(ifc.data_out), 32'h41);

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 3; i++) begin
            ifc.push = 1'b1; ifc.data_in = 8'(8'h50 + i);
            tick();
        end
        ifc.push = 1'b0;
        chk("ar_pre_count", 32'(ifc.count), 32'd3);
        #2;
        aresetn = 1'b0;
        #1;
        chk("ar_empty", 32'(ifc.empty), 32'd1);
        chk("ar_count", 32'(ifc.count), 32'd0);
        chk("ar_dout", 32'(ifc.data_out), 32'h00);
        chk("ar_unf", 32'(ifc.underflow), 32'd0);
        chk("ar_ovf", 32'(ifc.overflow), 32'd0);
        #1;
        aresetn = 1'b1;
        ifc.push = 1'b1; ifc.data_in = 8'h77;
        tick();
        ifc.push = 1'b0;
        chk("ar_post_dout", 32'(ifc.data_out), 32'h77);
        chk("ar_post_count", 32'(ifc.count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axicb_scfifo_fwft.md
Name: axicb_scfifo_fwft

Overview:
Single-clock first-word-fall-through FIFO. It is the parametrised successor of the crossbar's basic single-clock FIFO. A registered output stage presents the head word with no combinational path from push to data_out. The block adds:
- fill level
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow flags
- flush

It sits in crossbar master/slave interface buffers, where the arbiter needs backpressure before the FIFO is full and needs registered outputs for timing.

Parameters:
ADDR_WIDTH, 4, storage array depth = 2**ADDR_WIDTH; total capacity CAP = 2**ADDR_WIDTH + 1 (array plus output register).
DATA_WIDTH, 8, data word width.
AF_THRESH, 2**ADDR_WIDTH - 1, almost_full asserts when count >= AF_THRESH; legal range 1..CAP.
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..CAP-1.

Ports:
aclk  in  1  clock, rising edge.
aresetn  in  1  asynchronous active-low reset.
srst  in  1  synchronous reset; clears all state including the error flags.
flush  in  1  synchronous clear of contents; error flags are kept.
data_in  in  DATA_WIDTH  write data.
push  in  1  write request.
full  out  1  count == CAP.
data_out  out  DATA_WIDTH  head word, registered; valid when empty == 0.
pull  in  1  read request; consumes data_out.
empty  out  1  output register holds no valid word.
count  out  ADDR_WIDTH+1  words held, including the output register.
almost_full  out  1  count >= AF_THRESH, combinational from the count register.
almost_empty  out  1  count <= AE_THRESH, combinational from the count register.
overflow  out  1  sticky: push while full.
underflow  out  1  sticky: pull while empty.

Behaviour:
- Reset (aresetn low, or srst) gives:
  - wrptr = rdptr = 0 (ADDR_WIDTH+1 bits each)
  - count = 0, out_valid = 0, data_out = 0
  - overflow = underflow = 0
  - outputs: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THRESH == 0 ? 1 : 0).
- flush clears pointers, count and out_valid. data_out, overflow and underflow hold. flush has priority over push/pull in the same cycle.
- Accepted push: push & ~full. Accepted pull: pull & ~empty. full and empty are taken from the current registers only, so push is refused when full even if pull is accepted in the same cycle.
- Rejected push sets overflow; rejected pull sets underflow. Both are sticky until srst or aresetn.
- arr_cnt = wrptr - rdptr, i.e. the number of words in the array.
- Write routing for an accepted push:
  - If arr_cnt == 0 and (out_valid == 0, or a pull is accepted this cycle), the word loads into data_out directly. Latency push to visible output is 1 cycle.
  - Otherwise it is written to mem[wrptr[ADDR_WIDTH-1:0]] and wrptr increments.
- Output refill: if arr_cnt != 0 and (out_valid == 0, or a pull is accepted), data_out <= mem[rdptr] (asynchronous array read) and rdptr increments. Refill has priority over the direct path; both cannot apply in the same cycle because the direct path requires arr_cnt == 0.
- out_valid next = 1 if a refill or direct load occurs; 0 if a pull is accepted with no load; otherwise it holds.
- count next = count + accepted_push - accepted_pull. Simultaneous accept leaves count unchanged.
- Pointers wrap naturally at 2**(ADDR_WIDTH+1). Array full is when arr_cnt == 2**ADDR_WIDTH.
- No combinational path from push/pull to full, empty, data_out, count or the almost flags.

Decomposition:
- Package axicb_fifo_pkg holds:
  - function fifo_cap(aw) returning 2**aw + 1
  - threshold legality checks, used by elaboration-time asserts in the top module.
- Sub-module axicb_fifo_regfile: write-synchronous, read-asynchronous array with ports aclk, wr_en, addr_in, data_in, addr_out, data_out. Parameters ADDR_WIDTH and DATA_WIDTH. It has no reset.

Test Plan:
- Configuration for all scenarios: ADDR_WIDTH=2 (CAP=5), DATA_WIDTH=8, AF_THRESH=4, AE_THRESH=1.
- Single word: push 0xA5 at cycle 0 -> at cycle 1: empty=0, data_out=0xA5, count=1, almost_empty=1; pull at cycle 1 -> at cycle 2: empty=1, count=0.
- Fill: push 0x01..0x05 back-to-back -> almost_full at count 4, full at count 5; 6th push of 0x06 -> overflow=1, count stays 5. Drain 5 pulls -> data_out order 0x01..0x05, then empty=1.
- Streaming: push and pull every cycle with count=1 for 20 cycles, data 0x10..0x23 -> count stays 1, output sequence is exact, no error flags.
- Full with simultaneous push+pull -> push refused, overflow=1, count becomes 4.
- Pull while empty -> underflow=1, count=0. Then flush with 3 words held -> empty=1, count=0 next cycle, underflow still 1.
- aresetn asserted mid-stream with count=3 -> immediately: empty=1, count=0, data_out=0, flags cleared. After release, push 0x77 -> data_out=0x77 one cycle later.
